bdd_eval_engine: RTL and testbench

// - Programmable sequential evaluator for one learned output bit, stored as a BDD node table.
// - Replaces fixed per-bit combinational netlists: the same RTL serves any output bit; only the table differs.
// - Sits behind the cluster input-vector register; accepts one vector per handshake and returns the 1-bit result.
// - Adds a runtime-loadable table, a valid/ready stream interface and path-length overflow detection.

---
 rtl/bdd_eval_pkg.sv | 29 ++
 rtl/bdd_eval_engine_if.sv | 27 ++
 rtl/bdd_node_ram.sv | 24 ++
 rtl/bdd_eval_engine.sv | 104 ++++++++++
 tb/tb_bdd_eval_engine.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bdd_eval_pkg.sv
// rtl/bdd_eval_pkg.sv - shared types and constants for the BDD evaluation engine
package bdd_eval_pkg;

  localparam int IN_W      = 1894;
  localparam int NODES     = 128;
  localparam int NODE_AW   = 7;
  localparam int VAR_W     = 11;
  localparam int MAX_STEPS = 64;
  localparam int PW        = NODE_AW + 1;
  localparam int NODE_W    = VAR_W + 2 * PW;
  localparam int STEP_W    = $clog2(MAX_STEPS);

  typedef struct packed {
    logic [VAR_W-1:0] var_idx;
    logic [PW-1:0]    lo_ptr;
    logic [PW-1:0]    hi_ptr;
  } node_t;

  // Pointer MSB set marks a terminal whose value is carried in bit 0
  localparam logic [PW-1:0] PTR_TERM0 = {1'b1, {NODE_AW{1'b0}}};
  localparam logic [PW-1:0] PTR_TERM1 = {1'b1, {(NODE_AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  function automatic logic is_term(input logic [PW-1:0] p);
    return p[PW-1];
  endfunction

endpackage

// File: rtl/bdd_eval_engine_if.sv
// rtl/bdd_eval_engine_if.sv - table config and vector/result stream bundle
interface bdd_eval_engine_if;
  import bdd_eval_pkg::*;

  logic                cfg_we;
  logic [NODE_AW-1:0]  cfg_addr;
  logic [NODE_W-1:0]   cfg_wdata;
  logic [PW-1:0]       cfg_root;
  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     i;
  logic                out_valid;
  logic                out_ready;
  logic                o;
  logic                err;

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cfg_root, in_valid, i, out_ready,
    output in_ready, out_valid, o, err
  );

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cfg_root, in_valid, i, out_ready,
    input  in_ready, out_valid, o, err
  );

endinterface

// File: rtl/bdd_node_ram.sv
// rtl/bdd_node_ram.sv - node table, one synchronous write port and one asynchronous read port
module bdd_node_ram
  import bdd_eval_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [NODE_AW-1:0] waddr,
  input  node_t              wdata,
  input  logic [NODE_AW-1:0] raddr,
  output node_t              rdata
);

  // No reset: the table survives an engine reset and is reloaded by software
  node_t mem [NODES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bdd_eval_engine.sv
// rtl/bdd_eval_engine.sv - walks the node table for one input vector and returns the output bit
module bdd_eval_engine
  import bdd_eval_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  bdd_eval_engine_if.slave   bus
);

  localparam logic [VAR_W-1:0]  IN_W_V    = VAR_W'(IN_W);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

  state_t              state;
  logic [IN_W-1:0]     vec_q;
  logic [NODE_AW-1:0]  ptr_q;
  logic [STEP_W-1:0]   step;

  node_t               cur;
  node_t               wnode;
  logic                ram_we;
  logic [VAR_W-1:0]    sel_var;
  logic                bit_sel;
  logic [PW-1:0]       nxt;

  // Writes outside IDLE are dropped so the table cannot change under a walk
  assign ram_we = bus.cfg_we && (state == IDLE);
  assign wnode  = node_t'(bus.cfg_wdata);

  bdd_node_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (bus.cfg_addr),
    .wdata (wnode),
    .raddr (ptr_q),
    .rdata (cur)
  );

  // Out-of-range variable indices fall back to bit 0
  assign sel_var = (cur.var_idx < IN_W_V) ? cur.var_idx : '0;
  assign bit_sel = vec_q[sel_var];
  assign nxt     = bit_sel ? cur.hi_ptr : cur.lo_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      vec_q         <= '0;
      ptr_q         <= '0;
      step          <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.o         <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            vec_q        <= bus.i;
            ptr_q        <= bus.cfg_root[NODE_AW-1:0];
            step         <= '0;
            bus.in_ready <= 1'b0;
            if (is_term(bus.cfg_root)) begin
              bus.o         <= bus.cfg_root[0];
              bus.err       <= 1'b0;
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end else begin
              state <= WALK;
            end
          end
        end
        WALK: begin
          step <= step + 1'b1;
          if (is_term(nxt)) begin
            bus.o         <= nxt[0];
            bus.err       <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else if (step == STEP_LAST) begin
            // Path too long (or a cycle in the table): give up with err
            bus.o         <= 1'b0;
            bus.err       <= 1'b1;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            ptr_q <= nxt[NODE_AW-1:0];
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bdd_eval_engine.sv
// tb/tb_bdd_eval_engine.sv - scoreboard bench for bdd_eval_engine
module tb_bdd_eval_engine;

  localparam logic [7:0] T0 = 8'h80;
  localparam logic [7:0] T1 = 8'h81;

  typedef struct {
    logic o;
    logic err;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   first_cyc = 0;
  bit   seen = 1'b0;
  exp_t exp_q[$];

  bdd_eval_engine_if bus();

  bdd_eval_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: latency counted in clock edges after the accept edge
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) acc_cyc = cyc + 1;
      if (bus.out_valid && !seen) begin
        seen = 1'b1;
        first_cyc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got o=%0b err=%0b, required no beat", bus.o, bus.err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bus.o !== e.o || bus.err !== e.err || (first_cyc - acc_cyc) != e.lat) begin
            errors++;
            $display("FAIL result: got o=%0b err=%0b lat=%0d, required o=%0b err=%0b lat=%0d",
                     bus.o, bus.err, first_cyc - acc_cyc, e.o, e.err, e.lat);
          end
        end
        seen = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_node(input logic [6:0] a, input int v, input logic [7:0] lo, input logic [7:0] hi);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = {11'(v), lo, hi};
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic start(input logic [7:0] root, input logic [1893:0] vec,
                       input logic eo, input logic ee, input int el);
    exp_t e;
    e.o = eo; e.err = ee; e.lat = el;
    exp_q.push_back(e);
    bus.cfg_root = root;
    bus.i        = vec;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout: out_valid=%0b after %0d cycles, required 1", bus.out_valid, n);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic load_two_node();
    wr_node(7'd0, 87, T0, 8'h01);
    wr_node(7'd1, 1722, T0, T1);
  endtask

  task automatic test_reset();
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.cfg_root = '0;
    bus.in_valid = 1'b0; bus.i = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.o !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%0b vld=%0b o=%0b err=%0b, required 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.o, bus.err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_terminal_root();
    start(T1, '0, 1'b1, 1'b0, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL term_root_latency: got vld=%0b rdy=%0b, required 1 0", bus.out_valid, bus.in_ready);
    end
    wait_done();
    start(T0, '1, 1'b0, 1'b0, 0);
    wait_done();
  endtask

  task automatic test_two_node();
    logic [1893:0] v;
    load_two_node();
    v = '0; v[87] = 1'b1; v[1722] = 1'b1;
    start(8'h00, v, 1'b1, 1'b0, 2);
    wait_done();
    v = '0; v[1722] = 1'b1;
    start(8'h00, v, 1'b0, 1'b0, 1);
    wait_done();
    v = '0; v[87] = 1'b1;
    start(8'h00, v, 1'b0, 1'b0, 2);
    wait_done();
  endtask

  task automatic test_var_range();
    logic [1893:0] v;
    wr_node(7'd2, 2000, T0, T1);
    v = '0; v[0] = 1'b1;
    start(8'h02, v, 1'b1, 1'b0, 1);
    wait_done();
    v = '1; v[0] = 1'b0;
    start(8'h02, v, 1'b0, 1'b0, 1);
    wait_done();
    wr_node(7'd3, 1893, T0, T1);
    v = '0; v[1893] = 1'b1;
    start(8'h03, v, 1'b1, 1'b0, 1);
    wait_done();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    start(T1, '0, 1'b1, 1'b0, 0);
    bus.cfg_root = T0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (bus.out_valid !== 1'b1 || bus.o !== 1'b1 || bus.err !== 1'b0 || bus.in_ready !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: got %0d unstable cycles, required 0", bad);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_q.push_back('{1'b0, 1'b0, 0});
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: got rdy=%0b vld=%0b, required 1 0", bus.in_ready, bus.out_valid);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.o !== 1'b0) begin
      errors++;
      $display("FAIL second_accept: got rdy=%0b vld=%0b o=%0b, required 0 1 0",
               bus.in_ready, bus.out_valid, bus.o);
    end
    wait_done();
  endtask

  task automatic test_cfg_during_walk();
    logic [1893:0] v;
    load_two_node();
    v = '0; v[87] = 1'b1; v[1722] = 1'b1;
    start(8'h00, v, 1'b1, 1'b0, 2);
    wr_node(7'd0, 87, T0, T0);
    wait_done();
    wr_node(7'd0, 87, T0, T0);
    start(8'h00, v, 1'b0, 1'b0, 1);
    wait_done();
    // write on the accept edge is honoured and visible to that walk
    bus.cfg_we = 1'b1; bus.cfg_addr = 7'd0; bus.cfg_wdata = {11'd87, T0, T1};
    start(8'h00, v, 1'b1, 1'b0, 1);
    bus.cfg_we = 1'b0;
    wait_done();
  endtask

  task automatic test_self_loop();
    wr_node(7'd0, 5, 8'h00, 8'h00);
    start(8'h00, '0, 1'b0, 1'b1, 64);
    wait_done();
  endtask

  task automatic test_reset_mid_walk();
    logic [1893:0] v;
    load_two_node();
    v = '0; v[87] = 1'b1; v[1722] = 1'b1;
    start(8'h00, v, 1'b1, 1'b0, 2);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort: got vld=%0b rdy=%0b, required 0 1", bus.out_valid, bus.in_ready);
    end
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    start(8'h00, v, 1'b1, 1'b0, 2);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_terminal_root();
    test_two_node();
    test_var_range();
    test_backpressure();
    test_cfg_during_walk();
    test_self_loop();
    test_reset_mid_walk();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results: got %0d outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
